fire_control: RTL and testbench

- Upstream of the bullet blocks; turns the raw fire button into at most one fire request per press.
- Each request goes to exactly one idle bullet slot, rotating round-robin over NSLOT slots.
- Outputs drive each bullet's press and other inputs.
- It runs in the 100 MHz domain, gated by pixpulse, and fire requests line up with the frame-rate move strobe.

---
 rtl/fire_pkg.sv | 14 +
 rtl/btn_debounce.sv | 58 +++++
 rtl/fire_control.sv | 162 ++++++++++++++++
 tb/tb_fire_control.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fire_pkg.sv
// Shared types and default constants for the fire-button front end.
package fire_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2,
        COOL  = 2'd3
    } fire_state_e;

    localparam logic [15:0] DEBOUNCE_TICKS_DEF  = 16'd50000;
    localparam logic [3:0]  COOLDOWN_FRAMES_DEF = 4'd8;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter and a one-enable-wide
// rising-edge pulse of the debounced level. Reusable for any push button.
module btn_debounce
    import fire_pkg::*;
#(
    parameter logic [15:0] TICKS = DEBOUNCE_TICKS_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);

    localparam logic [15:0] LAST = TICKS - 16'd1;

    logic        r_meta;
    logic        r_sync;
    logic        r_samp;
    logic [15:0] r_cnt;
    logic        w_take;

    // Synchronizer runs every clock, independent of the enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_btn;
            r_sync <= r_meta;
        end
    end

    assign w_take = (r_sync == r_samp) && (r_cnt == LAST) && (o_level != r_samp);

    // Any change of the sampled level restarts the stability count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_samp  <= 1'b0;
            r_cnt   <= 16'd0;
            o_level <= 1'b0;
            o_rise  <= 1'b0;
        end else if (i_en) begin
            o_rise <= w_take & r_samp;
            if (r_sync != r_samp) begin
                r_samp <= r_sync;
                r_cnt  <= 16'd0;
            end else if (r_cnt != LAST) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (w_take) begin
                o_level <= r_samp;
            end
        end
    end

endmodule

// File: rtl/fire_control.sv
// Fire button to bullet-slot arbiter: one shot per debounced press, round-robin over
// idle slots, with a frame-based cooldown. Optional AUTOFIRE_EN re-fires while held.
module fire_control
    import fire_pkg::*;
#(
    parameter int unsigned NSLOT           = 2,
    parameter logic [15:0] DEBOUNCE_TICKS  = DEBOUNCE_TICKS_DEF,
    parameter logic [3:0]  COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pixpulse,
    input  logic             move,
    input  logic             btn_fire,
    input  logic [NSLOT-1:0] slot_idle,
    output logic [NSLOT-1:0] fire,
    output logic [NSLOT-1:0] other,
    output logic             cooldown,
    output logic [7:0]       shots,
    output logic [7:0]       drops
);

    localparam int unsigned    RRW       = (NSLOT > 1) ? $clog2(NSLOT) : 1;
    localparam logic [RRW-1:0] LAST_SLOT = RRW'(NSLOT - 1);

    fire_state_e      r_state;
    fire_state_e      w_state_n;
    logic [RRW-1:0]   r_slot;
    logic [RRW-1:0]   w_slot_n;
    logic [RRW-1:0]   r_rr;
    logic [RRW-1:0]   w_rr_n;
    logic [3:0]       r_cool;
    logic [3:0]       w_cool_n;
    logic [7:0]       w_shots_n;
    logic [7:0]       w_drops_n;
    logic [NSLOT-1:0] w_fire_n;
    logic [NSLOT-1:0] w_other_n;
    logic [RRW:0]     w_pick;
    logic             w_start;
    logic             w_level;
    logic             w_press;

    // First idle slot at or after ptr, wrapping; returns {found, index}.
    function automatic logic [RRW:0] rr_pick(input logic [NSLOT-1:0] idle,
                                             input logic [RRW-1:0]   ptr);
        logic             found;
        logic [RRW-1:0]   sel;
        logic [NSLOT-1:0] rot;
        int unsigned      idx;
        found = 1'b0;
        sel   = '0;
        for (int unsigned i = 0; i < NSLOT; i++) begin
            idx = (32'(ptr) + i) % NSLOT;
            rot = idle >> idx;
            if (!found && rot[0]) begin
                found = 1'b1;
                sel   = RRW'(idx);
            end
        end
        return {found, sel};
    endfunction

    btn_debounce #(
        .TICKS (DEBOUNCE_TICKS)
    ) u_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (pixpulse),
        .i_btn   (btn_fire),
        .o_level (w_level),
        .o_rise  (w_press)
    );

    // Next-state and next-output logic.
    always_comb begin
        w_state_n = r_state;
        w_slot_n  = r_slot;
        w_rr_n    = r_rr;
        w_cool_n  = r_cool;
        w_shots_n = shots;
        w_drops_n = drops;
        w_fire_n  = fire;
        w_other_n = other;
        w_start   = 1'b0;
        w_pick    = rr_pick(slot_idle, r_rr);

        unique case (r_state)
            IDLE: begin
                w_start = w_press & w_level;
            end
            GRANT: begin
                if ((slot_idle & fire) == '0) begin
                    // Slot was claimed elsewhere before the bullet sampled press.
                    w_state_n = IDLE;
                    w_fire_n  = '0;
                    w_other_n = '1;
                    w_drops_n = drops + 8'd1;
                end else if (move) begin
                    w_state_n = HOLD;
                    w_fire_n  = '0;
                    w_other_n = '1;
                    w_shots_n = shots + 8'd1;
                    w_rr_n    = (r_slot == LAST_SLOT) ? '0 : r_slot + RRW'(1);
                end
            end
            HOLD: begin
                w_state_n = COOL;
                w_cool_n  = COOLDOWN_FRAMES;
            end
            COOL: begin
                if (r_cool == 4'd0) begin
                    w_state_n = IDLE;
`ifdef AUTOFIRE_EN
                    w_start = w_level;
`endif
                end else if (move) begin
                    w_cool_n = r_cool - 4'd1;
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase

        if (w_start) begin
            if (w_pick[RRW]) begin
                w_state_n = GRANT;
                w_slot_n  = w_pick[RRW-1:0];
                w_fire_n  = NSLOT'(1) << w_pick[RRW-1:0];
                w_other_n = w_fire_n;
            end else begin
                w_drops_n = drops + 8'd1;
            end
        end
    end

    // All state advances on the pixel enable only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_slot   <= '0;
            r_rr     <= '0;
            r_cool   <= 4'd0;
            fire     <= '0;
            other    <= '1;
            cooldown <= 1'b0;
            shots    <= 8'd0;
            drops    <= 8'd0;
        end else if (pixpulse) begin
            r_state  <= w_state_n;
            r_slot   <= w_slot_n;
            r_rr     <= w_rr_n;
            r_cool   <= w_cool_n;
            fire     <= w_fire_n;
            other    <= w_other_n;
            cooldown <= (w_cool_n != 4'd0);
            shots    <= w_shots_n;
            drops    <= w_drops_n;
        end
    end

endmodule

// File: tb/tb_fire_control.sv
// Bench for fire_control: vector table of presses plus hand sequences for reset,
// bounce, cooldown and abandoned grants; shots are scoreboarded against expected slots.
module tb_fire_control;

    localparam int unsigned FRAME_PP = 16;
    localparam int unsigned FRAME_CK = FRAME_PP * 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pixpulse = 1'b0;
    logic       move = 1'b0;
    logic       btn_fire = 1'b0;
    logic [1:0] slot_idle = 2'b11;
    logic [1:0] fire;
    logic [1:0] other;
    logic       cooldown;
    logic [7:0] shots;
    logic [7:0] drops;

    fire_control #(
        .NSLOT           (2),
        .DEBOUNCE_TICKS  (16'd16),
        .COOLDOWN_FRAMES (4'd8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pixpulse  (pixpulse),
        .move      (move),
        .btn_fire  (btn_fire),
        .slot_idle (slot_idle),
        .fire      (fire),
        .other     (other),
        .cooldown  (cooldown),
        .shots     (shots),
        .drops     (drops)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] idle;
        bit         grant;
        int         slot;
        int         exp_shots;
        int         exp_drops;
    } vec_t;

    vec_t vecs[9];

    int checks = 0;
    int errors = 0;

    bit          run = 1'b0;
    int unsigned ck = 0;
    int unsigned pp = 0;
    int          frames = 0;
    int          nshots = 0;
    int          shot_frame = 0;
    logic [1:0]  obs_fire [256];
    logic [1:0]  obs_other[256];
    int          rd = 0;
    int          exp_q[$];

    // Enable/strobe generator and shot monitor; shot = fire seen on a pixpulse&move edge.
    always @(negedge clk) begin
        if (!run) begin
            pixpulse = 1'b0;
            move     = 1'b0;
        end else begin
            ck       = (ck + 1) % 4;
            pixpulse = (ck == 0);
            move     = 1'b0;
            if (pixpulse) begin
                pp   = (pp + 1) % FRAME_PP;
                move = (pp == 0);
            end
            if (move) frames++;
            if (pixpulse && move && rst_n && ((fire & slot_idle) != 2'b00) && nshots < 256) begin
                obs_fire[nshots]  = fire;
                obs_other[nshots] = other;
                shot_frame        = frames;
                nshots++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_check(input string name, input bit ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: wait bound expired", name);
        end
    endtask

    // Match every observed shot against the expected-slot queue.
    task automatic drain();
        int e;
        while (rd < nshots) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_shot: got fire %0b expected none", obs_fire[rd]);
            end else begin
                e = exp_q.pop_front();
                check("shot_fire", 32'(obs_fire[rd]), 32'(1) << e);
                check("shot_other", 32'(obs_other[rd]), 32'(1) << e);
            end
            rd++;
        end
    endtask

    task automatic press(input int hold_pp);
        btn_fire = 1'b1;
        repeat (hold_pp * 4) @(negedge clk);
        btn_fire = 1'b0;
    endtask

    task automatic wait_fire(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (fire != 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        bound_check(name, ok);
    endtask

    task automatic wait_frame(input int f);
        bit ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (frames >= f) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        bound_check("frame_wait", ok);
    endtask

    task automatic settle_check(input string name, input int exp_shots, input int exp_drops);
        drain();
        check({name, "_shots"}, 32'(shots), 32'(exp_shots));
        check({name, "_drops"}, 32'(drops), 32'(exp_drops));
        check({name, "_fire"}, 32'(fire), 32'd0);
        check({name, "_other"}, 32'(other), 32'd3);
        check({name, "_cooldown"}, 32'(cooldown), 32'd0);
        check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n0;
        vecs[0] = '{2'b11, 1'b1, 0, 1, 0};
        vecs[1] = '{2'b11, 1'b1, 1, 2, 0};
        vecs[2] = '{2'b11, 1'b1, 0, 3, 0};
        vecs[3] = '{2'b00, 1'b0, 0, 3, 1};
        vecs[4] = '{2'b10, 1'b1, 1, 4, 1};
        vecs[5] = '{2'b01, 1'b1, 0, 5, 1};
        vecs[6] = '{2'b10, 1'b1, 1, 6, 1};
        vecs[7] = '{2'b10, 1'b1, 1, 7, 1};
        vecs[8] = '{2'b01, 1'b1, 0, 8, 1};

        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        run   = 1'b1;
        @(negedge clk);
        check("rst_fire", 32'(fire), 32'd0);
        check("rst_other", 32'(other), 32'd3);
        check("rst_cooldown", 32'(cooldown), 32'd0);
        check("rst_shots", 32'(shots), 32'd0);
        check("rst_drops", 32'(drops), 32'd0);

        // Reset while a grant is pending must clear fire immediately.
        slot_idle = 2'b11;
        btn_fire  = 1'b1;
        wait_fire("midgrant_fire_wait");
        check("midgrant_fire", 32'(fire), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("midgrant_rst_fire", 32'(fire), 32'd0);
        check("midgrant_rst_other", 32'(other), 32'd3);
        check("midgrant_rst_shots", 32'(shots), 32'd0);
        check("midgrant_rst_drops", 32'(drops), 32'd0);
        btn_fire = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b1;
        repeat (4 * FRAME_CK) @(negedge clk);
        settle_check("post_reset", 0, 0);

        for (int i = 0; i < 9; i++) begin
            slot_idle = vecs[i].idle;
            if (vecs[i].grant) exp_q.push_back(vecs[i].slot);
            press(30);
            repeat (12 * FRAME_CK) @(negedge clk);
            settle_check($sformatf("vec%0d", i), vecs[i].exp_shots, vecs[i].exp_drops);
        end

        // Bouncing contact settles high: exactly one shot, to slot 1.
        slot_idle = 2'b11;
        exp_q.push_back(1);
        for (int t = 0; t < 10; t++) begin
            btn_fire = ~btn_fire;
            repeat (30) @(negedge clk);
        end
        press(30);
        repeat (12 * FRAME_CK) @(negedge clk);
        settle_check("bounce", 9, 1);

        // Second press during cooldown is discarded, not dropped.
        exp_q.push_back(0);
        n0 = nshots;
        press(30);
        for (int i = 0; i < 2000 && nshots == n0; i++) @(negedge clk);
        bound_check("cool_shot_wait", nshots != n0);
        n0 = shot_frame;
        repeat (32) @(negedge clk);
        check("cool_start", 32'(cooldown), 32'd1);
        wait_frame(n0 + 2);
        press(30);
        wait_frame(n0 + 7);
        repeat (32) @(negedge clk);
        check("cool_last_frame", 32'(cooldown), 32'd1);
        check("cool_shots", 32'(shots), 32'd10);
        check("cool_drops", 32'(drops), 32'd1);
        wait_frame(n0 + 8);
        repeat (32) @(negedge clk);
        check("cool_expired", 32'(cooldown), 32'd0);
        repeat (3 * FRAME_CK) @(negedge clk);
        settle_check("cool", 10, 1);

        // Slot goes busy before the move strobe: grant abandoned and counted as a drop.
        slot_idle = 2'b11;
        btn_fire  = 1'b1;
        wait_fire("abandon_fire_wait");
        check("abandon_grant_slot", 32'(fire), 32'd2);
        slot_idle = 2'b00;
        repeat (8) @(negedge clk);
        check("abandon_fire_clear", 32'(fire), 32'd0);
        check("abandon_other", 32'(other), 32'd3);
        btn_fire = 1'b0;
        repeat (3 * FRAME_CK) @(negedge clk);
        slot_idle = 2'b11;
        repeat (FRAME_CK) @(negedge clk);
        settle_check("abandon", 10, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
